camera_ray_gen: RTL and testbench
=================================

CAMERA_RAY_GEN -- requirements
Module: camera_ray_gen

Interface
REQ-001 Parameter D_BITS, default 32, width of each signed ray component word.
REQ-002 Parameter Q_BITS, default 16, fractional bits of each word; no arithmetic depends on it, informational only.
REQ-003 Parameter WIDTH, default 32, rays per row; HEIGHT, default 32, rows per frame; each SHALL be >= 1.
REQ-004 One clock; reset is asynchronous and active-low; ports SHALL be clock (input, 1, rising-edge clock) then reset_n (input, 1, async active-low reset).
REQ-005 start  input  1  single-cycle request to generate one frame of rays.
REQ-006 origin_in  input  3 x D_BITS signed  camera origin x,y,z.
REQ-007 dir_base_in / dir_dx_in / dir_dy_in  input  3 x D_BITS signed each  direction of pixel (0,0), per-column step, per-row step.
REQ-008 out_full  input  1  downstream ray FIFO full.
REQ-009 out_wr_en  output  1  ray write strobe to downstream FIFO.
REQ-010 ray_out  output  6 x D_BITS signed  [0..2] origin x,y,z; [3..5] direction x,y,z.
REQ-011 ray_index  output  clog2(WIDTH*HEIGHT)  linear index y*WIDTH+x of the ray on ray_out.
REQ-012 busy  output  1  high in EMIT state; done  output  1  one-cycle pulse at frame end.

Function
REQ-013 FSM states IDLE, EMIT, DONE; reset state IDLE.
REQ-014 IDLE: on start=1, SHALL register all configuration inputs, set x=0, y=0, row_dir=cur_dir=dir_base_in, enter EMIT next cycle; configuration inputs SHALL be ignored at all other times.
REQ-015 EMIT: out_wr_en SHALL equal !out_full combinationally; a transfer occurs on any rising edge with out_wr_en=1.
REQ-016 ray_out SHALL present registered origin and cur_dir; ray_out and ray_index SHALL be stable while out_full=1.
REQ-017 On transfer with x<WIDTH-1: x+=1, cur_dir+=dx (per component).
REQ-018 On transfer with x=WIDTH-1 and y<HEIGHT-1: x=0, y+=1, row_dir+=dy, cur_dir=row_dir+dy.
REQ-019 On transfer of ray WIDTH*HEIGHT-1: enter DONE.
REQ-020 DONE: done=1 for exactly one cycle, out_wr_en=0, then IDLE.
REQ-021 All additions SHALL be D_BITS two's-complement, wrapping modulo 2^D_BITS, no saturation, no multipliers.
REQ-022 Throughput SHALL be one ray per cycle with out_full=0; first transfer possible on the edge one cycle after start is sampled.
REQ-023 start while in EMIT or DONE SHALL be ignored; out_wr_en SHALL be 0 outside EMIT.
REQ-024 Exactly WIDTH*HEIGHT transfers per accepted start, in raster order, none duplicated or dropped regardless of out_full pattern.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, out_wr_en=0, busy=0, done=0, ray_out=0, ray_index=0, x=y=0.
REQ-026 Reset mid-frame SHALL abandon the frame; no done pulse; next start begins a fresh frame at index 0.

Configuration
REQ-027 Macro CAMERA_RAY_GEN_ABORT_EN: when defined, input port abort (1 bit) SHALL exist; abort=1 in EMIT forces out_wr_en=0 that cycle and IDLE next cycle, no done pulse; abort outside EMIT ignored.
REQ-028 Without CAMERA_RAY_GEN_ABORT_EN the abort port SHALL not exist and frames end only via completion or reset.

Verification
REQ-029 WIDTH=HEIGHT=32, origin=(0,0,0xFFFB0000), base=(0xFFFF0000,0xFFFF0000,0x00010000), dx=dy=(0x1000,0,0)/(0,0x1000,0), out_full=0 -> 1024 consecutive writes, ray 33 direction=(0xFFFF1000,0xFFFF1000,0x00010000), done one cycle after last write.
REQ-030 Same frame, out_full toggled pseudo-randomly (50%) -> still exactly 1024 writes, index sequence 0..1023, ray_out unchanged across every full cycle.
REQ-031 dx=(0x7FFFFFFF,0,0), base x=0x7FFFFFFF, WIDTH=2 -> ray 1 direction x=0xFFFFFFFE (wrap, no saturation).
REQ-032 reset_n pulsed low after ray 500 transfer -> out_wr_en=0 asynchronously, no done; new start -> ray_index 0 with new config.
REQ-033 start asserted again during EMIT with different dir_base_in -> ignored; frame output unchanged.
REQ-034 With CAMERA_RAY_GEN_ABORT_EN, abort at ray 100 -> no write that cycle, IDLE next, busy=0, done never pulses.

Source files
------------

// File: rtl/camera_ray_gen.sv
// Camera ray generator: streams one frame of WIDTH*HEIGHT primary rays in raster order.
// Optional abort input enabled by defining CAMERA_RAY_GEN_ABORT_EN.
`timescale 1ns/1ps
module camera_ray_gen #(
  parameter int unsigned D_BITS = 32,
  parameter int unsigned Q_BITS = 16,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32,
  localparam int unsigned TOTAL = WIDTH * HEIGHT,
  localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2:0][D_BITS-1:0] origin_in,
  input  logic [2:0][D_BITS-1:0] dir_base_in,
  input  logic [2:0][D_BITS-1:0] dir_dx_in,
  input  logic [2:0][D_BITS-1:0] dir_dy_in,
  input  logic                   out_full,
`ifdef CAMERA_RAY_GEN_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   out_wr_en,
  output logic [5:0][D_BITS-1:0] ray_out,
  output logic [IDX_W-1:0]       ray_index,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  if (WIDTH < 1 || HEIGHT < 1 || Q_BITS > D_BITS) begin : g_bad_params
    $error("camera_ray_gen: invalid parameters");
  end

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e                   state_q, state_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [2:0][D_BITS-1:0]   origin_q, origin_d;
  logic [2:0][D_BITS-1:0]   dx_q, dx_d;
  logic [2:0][D_BITS-1:0]   dy_q, dy_d;
  logic [2:0][D_BITS-1:0]   row_dir_q, row_dir_d;
  logic [2:0][D_BITS-1:0]   cur_dir_q, cur_dir_d;
  logic                     abort_req;

`ifdef CAMERA_RAY_GEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    origin_d  = origin_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    row_dir_d = row_dir_q;
    cur_dir_d = cur_dir_q;
    out_wr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StEmit;
          origin_d  = origin_in;
          dx_d      = dir_dx_in;
          dy_d      = dir_dy_in;
          row_dir_d = dir_base_in;
          cur_dir_d = dir_base_in;
          x_d       = '0;
          y_d       = '0;
          idx_d     = '0;
        end
      end
      StEmit: begin
        if (abort_req) begin
          state_d = StIdle;
        end else begin
          out_wr_en = !out_full;
          if (out_wr_en) begin
            if (idx_q == IDX_W'(TOTAL - 1)) begin
              state_d = StDone;
            end else if (x_q != XW'(WIDTH - 1)) begin
              idx_d = idx_q + 1'b1;
              x_d   = x_q + 1'b1;
              for (int i = 0; i < 3; i++) cur_dir_d[i] = cur_dir_q[i] + dx_q[i];
            end else begin
              // Row wrap: next row starts from the previous row start plus one dy step.
              idx_d = idx_q + 1'b1;
              x_d   = '0;
              y_d   = y_q + 1'b1;
              for (int i = 0; i < 3; i++) begin
                row_dir_d[i] = row_dir_q[i] + dy_q[i];
                cur_dir_d[i] = row_dir_q[i] + dy_q[i];
              end
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      origin_q  <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      row_dir_q <= '0;
      cur_dir_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      origin_q  <= origin_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      row_dir_q <= row_dir_d;
      cur_dir_q <= cur_dir_d;
    end
  end

  assign ray_out   = {cur_dir_q, origin_q};
  assign ray_index = idx_q;
  assign busy      = (state_q == StEmit);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_camera_ray_gen.sv
// Bench for camera_ray_gen: closed-form ray model checked every cycle plus directed cases.
`timescale 1ns/1ps
module tb_camera_ray_gen;
  localparam int unsigned W   = 32;
  localparam int unsigned H   = 32;
  localparam int unsigned TOT = W * H;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic out_full = 1'b0;
  logic [2:0][31:0] origin_in, dir_base_in, dir_dx_in, dir_dy_in;
  logic out_wr_en, busy, done;
  logic [5:0][31:0] ray_out;
  logic [9:0] ray_index;

  logic start2 = 1'b0;
  logic full2 = 1'b0;
  logic [2:0][31:0] org2, base2, dx2, dy2;
  logic wr2, busy2, done2;
  logic [5:0][31:0] ray2;
  logic [0:0] idx2;
`ifdef CAMERA_RAY_GEN_ABORT_EN
  logic abort = 1'b0;
  logic abort2 = 1'b0;
`endif

  camera_ray_gen #(.D_BITS(32), .Q_BITS(16), .WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .origin_in(origin_in), .dir_base_in(dir_base_in), .dir_dx_in(dir_dx_in),
    .dir_dy_in(dir_dy_in), .out_full(out_full),
`ifdef CAMERA_RAY_GEN_ABORT_EN
    .abort(abort),
`endif
    .out_wr_en(out_wr_en), .ray_out(ray_out), .ray_index(ray_index),
    .busy(busy), .done(done)
  );

  camera_ray_gen #(.D_BITS(32), .Q_BITS(16), .WIDTH(2), .HEIGHT(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .origin_in(org2), .dir_base_in(base2), .dir_dx_in(dx2),
    .dir_dy_in(dy2), .out_full(full2),
`ifdef CAMERA_RAY_GEN_ABORT_EN
    .abort(abort2),
`endif
    .out_wr_en(wr2), .ray_out(ray2), .ray_index(idx2),
    .busy(busy2), .done(done2)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Closed-form direction of ray idx: base + x*dx + y*dy, wrapping at 32 bits.
  function automatic logic [31:0] ray_dir(input logic [31:0] b, input logic [31:0] sx,
                                          input logic [31:0] sy, input int idx, input int w);
    logic [31:0] xx, yy;
    xx = 32'(idx % w);
    yy = 32'(idx / w);
    return b + xx * sx + yy * sy;
  endfunction

  // Model: phase 0 idle, 1 frame in progress, 2 frame-end cycle.
  int phase = 0;
  int k = 0;
  int writes = 0;
  logic [2:0][31:0] m_org, m_base, m_dx, m_dy;
  logic [2:0][31:0] cap33, cap1023;
  logic ab, exp_wr;

  always @(negedge clock) begin
`ifdef CAMERA_RAY_GEN_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    if (!reset_n) begin
      phase = 0;
      k = 0;
      chk("reset_wr_en", 64'(out_wr_en), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_index", 64'(ray_index), 64'd0);
      chk("reset_ray_nonzero", 64'(ray_out != '0), 64'd0);
    end else begin
      exp_wr = (phase == 1) && !out_full && !ab;
      chk("busy", 64'(busy), 64'(phase == 1));
      chk("done", 64'(done), 64'(phase == 2));
      chk("out_wr_en", 64'(out_wr_en), 64'(exp_wr));
      if (phase == 1) begin
        chk("ray_index", 64'(ray_index), 64'(k));
        for (int c = 0; c < 3; c++) begin
          chk("ray_origin", 64'(ray_out[c]), 64'(m_org[c]));
          chk("ray_dir", 64'(ray_out[3+c]), 64'(ray_dir(m_base[c], m_dx[c], m_dy[c], k, W)));
        end
      end
      if (phase == 2) phase = 0;
      else if (phase == 0) begin
        if (start) begin
          phase = 1; k = 0;
          m_org = origin_in; m_base = dir_base_in; m_dx = dir_dx_in; m_dy = dir_dy_in;
        end
      end else if (ab) phase = 0;
      else if (exp_wr) begin
        writes++;
        if (k == 33) cap33 = ray_out[5:3];
        if (k == 1023) cap1023 = ray_out[5:3];
        if (k == TOT - 1) phase = 2;
        else k++;
      end
    end
  end

  task automatic set_cfg(input logic [31:0] oz, input logic [31:0] bx, input logic [31:0] by,
                         input logic [31:0] bz);
    origin_in   = {oz, 32'h0, 32'h0};
    dir_base_in = {bz, by, bx};
    dir_dx_in   = {32'h0, 32'h0, 32'h0000_1000};
    dir_dy_in   = {32'h0, 32'h0000_1000, 32'h0};
  endtask

  task automatic start_frame();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (phase != 0 && n < limit) begin
      @(negedge clock); #1;
      n++;
    end
    chk(name, 64'(phase != 0), 64'd0);
  endtask

  initial begin
    set_cfg(32'hFFFB_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000);
    org2 = '0; dy2 = '0;
    base2 = {32'h0, 32'h0, 32'h7FFF_FFFF};
    dx2   = {32'h0, 32'h0, 32'h7FFF_FFFF};
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    chk("pin_model_r33_x", 64'(ray_dir(32'hFFFF_0000, 32'h1000, 32'h0, 33, 32)), 64'hFFFF_1000);
    chk("pin_model_r33_y", 64'(ray_dir(32'hFFFF_0000, 32'h0, 32'h1000, 33, 32)), 64'hFFFF_1000);

    // Full-rate frame
    writes = 0;
    start_frame();
    wait_idle(3000, "frame1_timeout");
    chk("frame1_writes", 64'(writes), 64'd1024);
    chk("r33_dir_x", 64'(cap33[0]), 64'hFFFF_1000);
    chk("r33_dir_y", 64'(cap33[1]), 64'hFFFF_1000);
    chk("r33_dir_z", 64'(cap33[2]), 64'h0001_0000);
    chk("r1023_dir_x", 64'(cap1023[0]), 64'h0000_F000);
    chk("r1023_dir_y", 64'(cap1023[1]), 64'h0000_F000);

    // Back-pressure frame
    writes = 0;
    start_frame();
    for (int n = 0; n < 8000 && phase != 0; n++) begin
      @(posedge clock); #1 out_full = 1'($urandom_range(0, 1));
    end
    out_full = 1'b0;
    wait_idle(10, "frame2_timeout");
    chk("frame2_writes", 64'(writes), 64'd1024);

    // Restart attempt mid-frame with a different base must be ignored
    writes = 0;
    start_frame();
    repeat (50) @(posedge clock);
    #1 dir_base_in = {32'h1234_0000, 32'h1111_0000, 32'h2222_0000}; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    set_cfg(32'hFFFB_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000);
    wait_idle(3000, "frame3_timeout");
    chk("frame3_writes", 64'(writes), 64'd1024);

    // Reset mid-frame after ray 500 has transferred
    start_frame();
    for (int n = 0; n < 2000 && ray_index != 10'd501; n++) @(posedge clock) #1;
    chk("reach_501", 64'(ray_index), 64'd501);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wr_en", 64'(out_wr_en), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_index", 64'(ray_index), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    set_cfg(32'h0000_0100, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    writes = 0;
    start_frame();
    chk("restart_index", 64'(ray_index), 64'd0);
    chk("restart_dir_x", 64'(ray_out[3]), 64'h0002_0000);
    wait_idle(3000, "frame4_timeout");
    chk("frame4_writes", 64'(writes), 64'd1024);

`ifdef CAMERA_RAY_GEN_ABORT_EN
    start_frame();
    for (int n = 0; n < 500 && ray_index != 10'd100; n++) @(posedge clock) #1;
    chk("reach_100", 64'(ray_index), 64'd100);
    abort = 1'b1;
    #1 chk("abort_wr_en", 64'(out_wr_en), 64'd0);
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clock);
`endif

    // Wrapping direction step on a 2x1 frame
    @(posedge clock); #1 start2 = 1'b1;
    @(posedge clock); #1 start2 = 1'b0;
    chk("wrap_r0_wr", 64'(wr2), 64'd1);
    chk("wrap_r0_idx", 64'(idx2), 64'd0);
    chk("wrap_r0_x", 64'(ray2[3]), 64'h7FFF_FFFF);
    @(posedge clock); #1;
    chk("wrap_r1_idx", 64'(idx2), 64'd1);
    chk("wrap_r1_x", 64'(ray2[3]), 64'hFFFF_FFFE);
    @(posedge clock); #1;
    chk("wrap_done", 64'(done2), 64'd1);
    chk("wrap_done_wr", 64'(wr2), 64'd0);
    @(posedge clock); #1;
    chk("wrap_done_once", 64'(done2), 64'd0);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
